// File: rtl/isp_vid_pack_if.sv
// Packed-word output stream of isp_vid_pack: valid/ready plus sof/eol frame tags.
interface isp_vid_pack_if #(
  parameter int BITS = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [4*BITS-1:0] out_data;
  logic              out_sof;
  logic              out_eol;

  modport master (output out_valid, output out_data, output out_sof, output out_eol, input out_ready);
  modport slave  (input out_valid, input out_data, input out_sof, input out_eol, output out_ready);
endinterface

// File: rtl/isp_vid_pack.sv
// Packs ISP pixels four per word, buffers them in a show-ahead FIFO and tracks
// per-frame line count and overflow drops.
module isp_vid_pack #(
  parameter int BITS       = 8,
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 960,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            pclk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            in_href,
  input  logic                            in_vsync,
  input  logic [BITS-1:0]                 in_data,
  isp_vid_pack_if.master                  m_out,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [15:0]                     ovf_cnt,
  output logic                            frame_done,
  output logic                            frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = 4 * BITS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || WIDTH < 4) begin : g_bad_cfg
    $error("isp_vid_pack: FIFO_DEPTH must be a power of 2 >= 4 and WIDTH >= 4");
  end

  logic                    r_href, r_vsync, r_href_d, r_vsync_d;
  logic [BITS-1:0]         r_data;
  logic [1:0]              r_state;
  logic [3:0][BITS-1:0]    r_pack;
  logic [1:0]              r_pix_idx;
  logic [15:0]             r_line_cnt;
  logic                    r_pend_sof;
  logic                    r_push_vld;
  logic [WW-1:0]           r_push_data;
  logic                    r_push_eol;
  logic [WW+1:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]           r_level;
  logic [15:0]             r_ovf;
  logic                    r_done, r_err;

  logic w_vs_rise, w_vs_fall, w_href_fall, w_start, w_pix, w_eol_end, w_retag;
  logic w_full, w_wr, w_drop, w_rd, w_flush_done, w_valid;
  logic [WW+1:0] w_head;

  assign w_vs_rise    = r_vsync & ~r_vsync_d;
  assign w_vs_fall    = ~r_vsync & r_vsync_d;
  assign w_href_fall  = ~r_href & r_href_d;
  assign w_start      = (r_state == S_IDLE) & w_vs_rise & en;
  assign w_pix        = (r_state == S_ACTIVE) & r_href;
  // Line ends are honoured in FLUSH too, so a line closing just after vsync falls still flushes.
  assign w_eol_end    = (r_state != S_IDLE) & w_href_fall;
  // Full line of whole words: the word staged last cycle is still in flight, tag it here.
  assign w_retag      = w_eol_end & (r_pix_idx == 2'd0) & r_push_vld;
  assign w_full       = (r_level == LW'(FIFO_DEPTH));
  assign w_wr         = r_push_vld & ~w_full;
  assign w_drop       = r_push_vld & w_full;
  assign w_valid      = (r_level != '0);
  assign w_rd         = w_valid & m_out.out_ready;
  assign w_flush_done = (r_state == S_FLUSH) & (r_level == '0) & ~r_push_vld & ~w_href_fall;
  assign w_head       = r_mem[r_rd_ptr];

  assign m_out.out_valid = w_valid;
  assign m_out.out_data  = w_valid ? w_head[WW-1:0] : '0;
  assign m_out.out_eol   = w_valid & w_head[WW];
  assign m_out.out_sof   = w_valid & w_head[WW+1];
  assign fifo_level      = r_level;
  assign ovf_cnt         = r_ovf;
  assign frame_done      = r_done;
  assign frame_err       = r_err;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_href    <= 1'b0;
      r_vsync   <= 1'b0;
      r_href_d  <= 1'b0;
      r_vsync_d <= 1'b0;
      r_data    <= '0;
    end else begin
      r_href    <= in_href;
      r_vsync   <= in_vsync;
      r_data    <= in_data;
      r_href_d  <= r_href;
      r_vsync_d <= r_vsync;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_flush_done;
      r_err  <= w_flush_done & (r_line_cnt != 16'(HEIGHT));
      case (r_state)
        S_IDLE:   if (w_start)      r_state <= S_ACTIVE;
        S_ACTIVE: if (w_vs_fall)    r_state <= S_FLUSH;
        S_FLUSH:  if (w_flush_done) r_state <= S_IDLE;
        default:                    r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pack      <= '0;
      r_pix_idx   <= 2'd0;
      r_line_cnt  <= '0;
      r_push_vld  <= 1'b0;
      r_push_data <= '0;
      r_push_eol  <= 1'b0;
    end else begin
      r_push_vld  <= (w_pix & (r_pix_idx == 2'd3)) | (w_eol_end & (r_pix_idx != 2'd0));
      r_push_data <= w_pix ? {r_data, r_pack[2:0]} : r_pack;
      r_push_eol  <= ~w_pix & w_eol_end;
      if (w_start) begin
        r_pack     <= '0;
        r_pix_idx  <= 2'd0;
        r_line_cnt <= '0;
      end else if (w_pix) begin
        if (r_pix_idx == 2'd3) r_pack <= '0;
        else                   r_pack[r_pix_idx] <= r_data;
        r_pix_idx <= r_pix_idx + 2'd1;
      end else if (w_eol_end) begin
        r_pack    <= '0;
        r_pix_idx <= 2'd0;
        if (r_line_cnt != 16'hFFFF) r_line_cnt <= r_line_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_ovf      <= '0;
      r_pend_sof <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_wr) - LW'(w_rd);
      if (w_start)                          r_ovf <= '0;
      else if (w_drop && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 16'd1;
      if (w_start)   r_pend_sof <= 1'b1;
      else if (w_wr) r_pend_sof <= 1'b0;
    end
  end

  // Storage needs no reset: pointers and level define what is live.
  always_ff @(posedge pclk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_pend_sof, r_push_eol | w_retag, r_push_data};
  end
endmodule

// File: tb/tb_isp_vid_pack.sv
// Directed bench for isp_vid_pack with a word scoreboard fed by the pixel driver.
module tb_isp_vid_pack;
  localparam int BITS   = 8;
  localparam int DEPTH  = 16;
  localparam int HEIGHT = 4;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_href = 1'b0;
  logic        in_vsync = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [4:0]  fifo_level;
  logic [15:0] ovf_cnt;
  logic        frame_done, frame_err;

  isp_vid_pack_if #(.BITS(BITS)) vif();

  isp_vid_pack #(.BITS(BITS), .WIDTH(1280), .HEIGHT(HEIGHT), .FIFO_DEPTH(DEPTH)) dut (
    .pclk(pclk), .rst_n(rst_n), .en(en), .in_href(in_href), .in_vsync(in_vsync),
    .in_data(in_data), .m_out(vif.master), .fifo_level(fifo_level), .ovf_cnt(ovf_cnt),
    .frame_done(frame_done), .frame_err(frame_err));

  always #5 pclk = ~pclk;

  int          checks = 0;
  int          errors = 0;
  logic [33:0] sb[$];
  int          rx_cnt = 0;
  int          done_cnt = 0;
  logic        last_err = 1'b0;
  bit          sb_sof = 1'b0;
  int          sb_cap = 0;
  bit          toggle_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic sb_push(input logic [31:0] w, input logic eol);
    if (sb_cap > 0) begin
      sb.push_back({sb_sof, eol, w});
      sb_sof = 1'b0;
      sb_cap--;
    end
  endtask

  task automatic send_line(input int n, input logic [7:0] base);
    logic [31:0] w;
    int k;
    w = '0;
    k = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      in_href = 1'b1;
      in_data = 8'(int'(base) + i);
      w[k*8 +: 8] = in_data;
      k++;
      if (k == 4) begin
        sb_push(w, i == n - 1);
        w = '0;
        k = 0;
      end
    end
    tick();
    in_href = 1'b0;
    if (k != 0) sb_push(w, 1'b1);
    repeat (3) tick();
  endtask

  task automatic start_frame();
    tick();
    in_vsync = 1'b1;
    sb_sof = 1'b1;
    repeat (3) tick();
  endtask

  task automatic end_frame();
    tick();
    in_vsync = 1'b0;
  endtask

  task automatic wait_done(input int prior, input string tag);
    int t;
    t = 0;
    while (done_cnt == prior && t < 500) begin
      tick();
      t++;
    end
    chk(tag, done_cnt, prior + 1);
  endtask

  // Output monitor: scoreboard pops, hold-while-stalled checks, frame_done capture.
  initial begin
    logic        p_v, p_r;
    logic [31:0] p_d;
    logic [33:0] exp;
    p_v = 1'b0;
    p_r = 1'b0;
    p_d = '0;
    forever begin
      @(negedge pclk);
      if (!rst_n) begin
        p_v = 1'b0;
      end else begin
        if (p_v && !p_r) begin
          chk("hold_valid", vif.out_valid, 1);
          chk("hold_data", vif.out_data, p_d);
        end
        if (vif.out_valid && vif.out_ready) begin
          checks++;
          assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL extra_word observed=%0h expected=none", vif.out_data);
          end
          if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk("word", {vif.out_sof, vif.out_eol, vif.out_data}, exp);
          end
          rx_cnt++;
        end
        if (frame_done) begin
          done_cnt++;
          last_err = frame_err;
        end
        p_v = vif.out_valid;
        p_r = vif.out_ready;
        p_d = vif.out_data;
      end
    end
  end

  initial begin
    forever begin
      tick();
      if (toggle_en) vif.out_ready = ~vif.out_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, r0;
    vif.out_ready = 1'b1;
    en = 1'b1;
    repeat (3) tick();
    chk("rst_valid", vif.out_valid, 0);
    chk("rst_data", vif.out_data, 0);
    chk("rst_sof", vif.out_sof, 0);
    chk("rst_eol", vif.out_eol, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", ovf_cnt, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Full frame of 4 lines x 8 pixels
    d = done_cnt; r0 = rx_cnt; sb_cap = 1000;
    start_frame();
    repeat (HEIGHT) send_line(8, 8'h00);
    end_frame();
    wait_done(d, "t1_done");
    chk("t1_err", last_err, 0);
    chk("t1_ovf", ovf_cnt, 0);
    chk("t1_words", rx_cnt - r0, 8);
    chk("t1_sb_empty", sb.size(), 0);

    // Short frame of 6-pixel lines: partial words and line-count error
    d = done_cnt; r0 = rx_cnt;
    start_frame();
    repeat (3) send_line(6, 8'hA0);
    end_frame();
    wait_done(d, "t2_done");
    chk("t2_err", last_err, 1);
    chk("t2_words", rx_cnt - r0, 6);

    // Overflow with sink stalled
    vif.out_ready = 1'b0;
    d = done_cnt; r0 = rx_cnt; sb_cap = DEPTH;
    start_frame();
    send_line(80, 8'h00);
    repeat (5) tick();
    chk("t3_level_full", fifo_level, DEPTH);
    chk("t3_ovf", ovf_cnt, 4);
    end_frame();
    repeat (10) tick();
    chk("t3_done_waits", done_cnt, d);
    chk("t3_level_hold", fifo_level, DEPTH);
    vif.out_ready = 1'b1;
    wait_done(d, "t3_done");
    chk("t3_err", last_err, 1);
    chk("t3_words", rx_cnt - r0, DEPTH);
    chk("t3_level_empty", fifo_level, 0);
    sb_cap = 1000;

    // Sink ready toggling every cycle
    d = done_cnt; r0 = rx_cnt;
    toggle_en = 1'b1;
    start_frame();
    repeat (HEIGHT) send_line(8, 8'h10);
    end_frame();
    wait_done(d, "t4_done");
    toggle_en = 1'b0;
    tick();
    vif.out_ready = 1'b1;
    chk("t4_err", last_err, 0);
    chk("t4_words", rx_cnt - r0, 8);
    chk("t4_sb_empty", sb.size(), 0);

    // Frame started with capture disabled
    en = 1'b0;
    d = done_cnt; r0 = rx_cnt; sb_cap = 0;
    start_frame();
    repeat (2) send_line(8, 8'h20);
    end_frame();
    repeat (30) tick();
    chk("t5_no_words", rx_cnt, r0);
    chk("t5_no_done", done_cnt, d);
    chk("t5_level", fifo_level, 0);
    en = 1'b1;
    sb_cap = 1000;

    // Asynchronous reset in the middle of a line with 5 words held
    vif.out_ready = 1'b0;
    d = done_cnt;
    start_frame();
    for (int i = 0; i < 23; i++) begin
      tick();
      in_href = 1'b1;
      in_data = 8'(i);
    end
    chk("t6_level_pre", fifo_level, 5);
    rst_n = 1'b0;
    #1;
    chk("t6_level_rst", fifo_level, 0);
    chk("t6_valid_rst", vif.out_valid, 0);
    in_href = 1'b0;
    in_vsync = 1'b0;
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("t6_no_done", done_cnt, d);
    vif.out_ready = 1'b1;
    r0 = rx_cnt;
    start_frame();
    send_line(4, 8'h55);
    end_frame();
    wait_done(d, "t6_done");
    chk("t6_err", last_err, 1);
    chk("t6_ovf", ovf_cnt, 0);
    chk("t6_words", rx_cnt - r0, 1);
    chk("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/isp_vid_pack.md
Name: isp_vid_pack

Overview:
- Sits directly downstream of the ISP pipeline output (out_href/out_vsync/out_y) and upstream of the SDRAM frame writer.
- Packs BITS-wide pixels four at a time into 4*BITS-bit words and buffers them in an internal FIFO.
- Presents words on a valid/ready interface with start-of-frame and end-of-line tags.
- Counts words dropped on overflow and reports per-frame completion with a line-count check.

Parameters:
- BITS, 8, pixel width.
- WIDTH, 1280, nominal pixels per line; informational only, not checked.
- HEIGHT, 960, expected href lines per frame; checked at frame end.
- FIFO_DEPTH, 16, word capacity including the output register; power of 2, minimum 4.

Ports:
- pclk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  capture enable; sampled only at frame start.
- in_href  in  1  line-valid; a pixel is valid in every cycle where in_href=1.
- in_vsync  in  1  frame-active level; rising edge = frame start, falling edge = frame end.
- in_data  in  BITS  pixel.
- out_valid  out  1  word available.
- out_ready  in  1  sink accepts the word when out_valid=1 and out_ready=1.
- out_data  out  4*BITS  packed word; pixel k occupies bits [(k+1)*BITS-1:k*BITS], pixel 0 is the earliest.
- out_sof  out  1  word is the first word stored in this frame.
- out_eol  out  1  word is the last word of a line.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words held, including the output register.
- ovf_cnt  out  16  dropped-word count; saturates at 16'hFFFF; cleared at frame start.
- frame_done  out  1  one-cycle pulse at frame completion.
- frame_err  out  1  valid with frame_done; 1 if lines != HEIGHT.

Behaviour:
- Reset: all outputs 0. State=IDLE. FIFO empty. Pack register, pixel index, line counter and pending-sof flag are cleared.
- in_href, in_vsync and in_data are registered once internally; edge detection uses that registered copy.

State machine:
- IDLE: on a vsync rising edge with en=1, go to ACTIVE. In the same cycle: clear line counter and ovf_cnt, set pending_sof=1. With en=0, stay in IDLE and ignore the whole frame.
- ACTIVE: packing as described below. On a vsync falling edge, go to FLUSH.
- FLUSH: wait until fifo_level==0. Then pulse frame_done for one cycle, with frame_err=(line_count!=HEIGHT). Then return to IDLE.
- Deasserting en mid-frame has no effect until the next frame start.

Packing (ACTIVE only):
- Each href=1 pixel is written into slot pixel_idx (0..3). pixel_idx wraps 3→0.
- When slot 3 is written, push the word with eol=0.
- On an href falling edge:
  - if pixel_idx!=0, push the partial word with unfilled slots zero, eol=1;
  - if pixel_idx==0, retag the last word pushed in that line as eol=1. That word is still held, since a push occurred the previous cycle and it cannot have left within one cycle.
  - Then reset pixel_idx and increment the line counter. The line counter saturates at 16 bits.
- A push that occurs while pending_sof=1 carries sof=1 and clears pending_sof. A dropped word does not clear it.
- Pixels arriving in the same cycle as the vsync falling edge are packed normally, and the partial-word flush still applies.

FIFO:
- Entries are 4*BITS+2 bits wide (data, sof, eol).
- full = (fifo_level==FIFO_DEPTH), evaluated at the start of the cycle. A push while full is dropped even if a pop occurs in the same cycle, and ovf_cnt increments.
- Simultaneous push and pop when not full leaves fifo_level unchanged.
- Output register: out_data, out_sof and out_eol hold stable while out_valid=1 and out_ready=0.
- Pop occurs on out_valid & out_ready. The next entry appears in the following cycle with no bubble if available.

Latency:
- Pixel 3 of a word is sampled at the input pins in cycle N.
- Into an empty block, out_valid rises at N+3 (input register, pack/push, output register).

Reset mid-operation: asynchronously clears everything, including the FIFO contents. No frame_done is produced.

Test Plan:
- 1 frame, HEIGHT=4, 8-pixel lines of values 0x00..0x07, out_ready=1:
  - 8 words, first 0x03020100 with sof=1;
  - every second word eol=1;
  - frame_done=1 with frame_err=0, ovf_cnt=0.
- 6-pixel line (0xA0..0xA5): words 0xA3A2A1A0 (eol=0) and 0x0000A5A4 (eol=1).
- FIFO_DEPTH=16, out_ready=0, one 80-pixel line:
  - 20 words offered, 16 stored, ovf_cnt=4, fifo_level=16;
  - after out_ready=1 the 16th word has eol=0, and frame_done waits until fifo_level=0.
- out_ready toggled 1/0 every cycle: out_data never changes while valid&!ready; all words delivered in order with no duplicates.
- Frame with 3 lines for HEIGHT=4 → frame_err=1 with frame_done. Frame started with en=0 → no output words and no frame_done.
- rst_n pulsed low mid-line with fifo_level=5 → fifo_level=0 and out_valid=0 immediately; next frame's first word has sof=1 and ovf_cnt=0.
